// File: rtl/data_mem.sv
// rtl/data_mem.sv - 1 KiB byte-addressable little-endian data memory, combinational load, clocked store
// Optional feature macro: DATAMEM_BOUNDS_CHECK_EN (suppresses out-of-range accesses instead of aliasing).
module data_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        WriteEn,
    input  logic [31:0] address,
    input  logic [31:0] datain,
    input  logic [1:0]  datasize,
    input  logic        datatype,
    output logic [31:0] dataout
);

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    logic [7:0]  mem [0:1023];
    logic [9:0]  base;
    logic [3:0]  lane_en;
    logic        access_ok;
    logic [7:0]  rd [0:3];

    assign base = address[9:0];

    // Lanes touched by the access; the reserved size touches none, so it never stores.
    always_comb begin
        lane_en = 4'b0000;
        case (datasize)
            SIZE_WORD: lane_en = 4'b1111;
            SIZE_HALF: lane_en = 4'b0011;
            SIZE_BYTE: lane_en = 4'b0001;
            default:   lane_en = 4'b0000;
        endcase
    end

`ifdef DATAMEM_BOUNDS_CHECK_EN
    logic [10:0] last_idx;

    always_comb begin
        last_idx = {1'b0, base};
        case (datasize)
            SIZE_WORD: last_idx = {1'b0, base} + 11'd3;
            SIZE_HALF: last_idx = {1'b0, base} + 11'd1;
            default:   last_idx = {1'b0, base};
        endcase
    end

    assign access_ok = (address[31:10] == 22'd0) && !last_idx[10];
`else
    logic unused_high_addr;

    assign unused_high_addr = ^address[31:10];
    assign access_ok        = 1'b1;
`endif

    // Each byte decides for itself whether it is hit: its distance from base (mod 1024) picks the lane.
    for (genvar g = 0; g < 1024; g++) begin : g_byte
        logic [9:0] off;
        logic       hit;

        assign off = 10'(g) - base;
        assign hit = WriteEn && access_ok && (off[9:2] == 8'd0) && lane_en[off[1:0]];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem[g] <= 8'h00;
            end else if (hit) begin
                mem[g] <= datain[8*off[1:0] +: 8];
            end
        end
    end

    for (genvar l = 0; l < 4; l++) begin : g_rd
        assign rd[l] = mem[base + 10'(l)];
    end

    always_comb begin
        dataout = 32'h0000_0000;
        if (reset && access_ok) begin
            case (datasize)
                SIZE_WORD: dataout = {rd[3], rd[2], rd[1], rd[0]};
                SIZE_HALF: dataout = {{16{!datatype && rd[1][7]}}, rd[1], rd[0]};
                SIZE_BYTE: dataout = {{24{!datatype && rd[0][7]}}, rd[0]};
                default:   dataout = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - table-driven self-checking bench for data_mem with an expected-value queue
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic        WriteEn;
    logic [31:0] address;
    logic [31:0] datain;
    logic [1:0]  datasize;
    logic        datatype;
    logic [31:0] dataout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_rd;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        bit          dtype;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    data_mem dut (
        .clk      (clk),
        .reset    (reset),
        .WriteEn  (WriteEn),
        .address  (address),
        .datain   (datain),
        .datasize (datasize),
        .datatype (datatype),
        .dataout  (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_w(bit we, logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        vec_t v;
        v.is_rd = 1'b0; v.we = we; v.addr = a; v.data = d; v.size = sz; v.dtype = 1'b0; v.exp = 32'h0;
        vecs.push_back(v);
    endfunction

    function automatic void add_r(logic [31:0] a, logic [1:0] sz, bit dt, logic [31:0] e);
        vec_t v;
        v.is_rd = 1'b1; v.we = 1'b0; v.addr = a; v.data = 32'h0; v.size = sz; v.dtype = dt; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_pop(string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got 0x%08h expected <entry>", name, dataout);
        end else begin
            e = exp_q.pop_front();
            check(name, dataout, e);
        end
    endtask

    task automatic do_write(bit we, logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        @(negedge clk);
        WriteEn = we; address = a; datain = d; datasize = sz; datatype = 1'b0;
        @(posedge clk);
        #1;
        WriteEn = 1'b0;
    endtask

    task automatic do_read(logic [31:0] a, logic [1:0] sz, bit dt, logic [31:0] e, string name);
        @(negedge clk);
        WriteEn = 1'b0; address = a; datasize = sz; datatype = dt;
        exp_q.push_back(e);
        #1;
        check_pop(name);
    endtask

    initial begin
        reset = 1'b0; WriteEn = 1'b0; address = 32'h4; datain = 32'h0; datasize = 2'b00; datatype = 1'b0;

        add_w(1, 32'h04, 32'h1234_5678, 2'b00);
        add_r(32'h04, 2'b00, 0, 32'h1234_5678);
        add_r(32'h04, 2'b00, 1, 32'h1234_5678);
        add_r(32'h05, 2'b10, 1, 32'h0000_0056);
        add_r(32'h04, 2'b01, 0, 32'h0000_5678);
        add_r(32'h06, 2'b00, 0, 32'h0000_1234);
        add_w(0, 32'h08, 32'hDEAD_BEEF, 2'b00);
        add_r(32'h08, 2'b00, 0, 32'h0000_0000);
        add_w(1, 32'h40, 32'h1212_EFEF, 2'b01);
        add_w(1, 32'h42, 32'hEFEF_1212, 2'b01);
        add_r(32'h40, 2'b01, 0, 32'hFFFF_EFEF);
        add_r(32'h40, 2'b01, 1, 32'h0000_EFEF);
        add_r(32'h42, 2'b01, 0, 32'h0000_1212);
        add_r(32'h42, 2'b01, 1, 32'h0000_1212);
        add_r(32'h40, 2'b00, 0, 32'h1212_EFEF);
        for (int i = 0; i < 5; i++) add_w(1, 32'h50 + i, 32'hFFFF_0040 + i, 2'b10);
        for (int i = 0; i < 5; i++) add_r(32'h50 + i, 2'b10, 1, 32'h0000_0040 + i);
        add_w(1, 32'h60, 32'h0000_0080, 2'b10);
        add_r(32'h60, 2'b10, 0, 32'hFFFF_FF80);
        add_r(32'h60, 2'b10, 1, 32'h0000_0080);
        add_r(32'h60, 2'b01, 0, 32'h0000_0080);
        add_w(1, 32'h70, 32'hAAAA_AAAA, 2'b11);
        add_r(32'h70, 2'b11, 0, 32'h0000_0000);
        add_r(32'h70, 2'b00, 0, 32'h0000_0000);
        add_r(32'h04, 2'b11, 1, 32'h0000_0000);
        add_w(1, 32'h3FE, 32'hCAFE_BABE, 2'b00);
`ifdef DATAMEM_BOUNDS_CHECK_EN
        add_r(32'h404, 2'b00, 0, 32'h0000_0000);
        add_r(32'h3FE, 2'b10, 1, 32'h0000_0000);
        add_r(32'h3FF, 2'b10, 1, 32'h0000_0000);
        add_r(32'h000, 2'b10, 1, 32'h0000_0000);
        add_r(32'h001, 2'b10, 1, 32'h0000_0000);
        add_r(32'h3FE, 2'b00, 0, 32'h0000_0000);
`else
        add_r(32'h404, 2'b00, 0, 32'h1234_5678);
        add_r(32'h3FE, 2'b10, 1, 32'h0000_00BE);
        add_r(32'h3FF, 2'b10, 1, 32'h0000_00BA);
        add_r(32'h000, 2'b10, 1, 32'h0000_00FE);
        add_r(32'h001, 2'b10, 1, 32'h0000_00CA);
        add_r(32'h3FE, 2'b00, 0, 32'hCAFE_BABE);
`endif

        #1;
        check("reset_dataout", dataout, 32'h0000_0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_word4", dataout, 32'h0000_0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_rd)
                do_read(vecs[i].addr, vecs[i].size, vecs[i].dtype, vecs[i].exp, $sformatf("vec%0d", i));
            else
                do_write(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].size);
        end

        // Read and write of the same bytes on one edge: old data before, new data right after.
        @(negedge clk);
        address = 32'h80; datasize = 2'b00; datatype = 1'b0; datain = 32'h1122_3344; WriteEn = 1'b1;
        #1;
        check("rw_same_before", dataout, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rw_same_after", dataout, 32'h1122_3344);
        WriteEn = 1'b0;

        // Asynchronous reset between edges, store attempted while reset is low.
        @(negedge clk);
        address = 32'h04; datasize = 2'b00;
        #1;
        check("pre_reset_word4", dataout, 32'h1234_5678);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_word4", dataout, 32'h0000_0000);
        @(negedge clk);
        WriteEn = 1'b1; datain = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        WriteEn = 1'b0;
        check("store_in_reset_dataout", dataout, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("store_in_reset_ignored", dataout, 32'h0000_0000);
        address = 32'h50; datasize = 2'b10; datatype = 1'b1;
        #1;
        check("reset_cleared_0x50", dataout, 32'h0000_0000);

        // First edge after release must already accept a store.
        address = 32'h10; datasize = 2'b00; datain = 32'h0A0B_0C0D; WriteEn = 1'b1;
        @(posedge clk);
        #1;
        WriteEn = 1'b0;
        check("first_edge_after_release", dataout, 32'h0A0B_0C0D);
        do_read(32'h80, 2'b00, 0, 32'h0000_0000, "reset_cleared_0x80");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock for all writes.
REQ-002 The block SHALL have ports: reset  input  1  asynchronous, active-low reset; clears memory.
REQ-003 The block SHALL have ports: WriteEn  input  1  store enable, sampled at rising clk.
REQ-004 The block SHALL have ports: address  input  32  byte address for load and store.
REQ-005 The block SHALL have ports: datain  input  32  store data; the low bytes are used for half and byte stores.
REQ-006 The block SHALL have ports: datasize  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-007 The block SHALL have ports: datatype  input  1  load extension: 0 signed, 1 unsigned.
REQ-008 The block SHALL have ports: dataout  output  32  load result.

Function
REQ-009 Storage SHALL be 1024 bytes, byte-addressable, little-endian, with byte index = address[9:0].
REQ-010 A store SHALL occur on a rising clk when WriteEn=1 and reset=1.
REQ-011 Word stores SHALL write datain[7:0..31:24] to bytes A, A+1, A+2 and A+3.
REQ-012 Half stores SHALL write datain[7:0] to byte A and datain[15:8] to byte A+1.
REQ-013 Byte stores SHALL write datain[7:0] to byte A.
REQ-014 Byte offsets SHALL wrap modulo 1024.
REQ-015 Misaligned addresses SHALL be legal for all sizes, with no alignment trap.
REQ-016 datasize=11 SHALL suppress the store, and the load SHALL return 0x00000000.
REQ-017 Loads SHALL be combinational: dataout SHALL follow address, datasize, datatype and memory contents with zero clock latency.
REQ-018 Word loads SHALL return {A+3, A+2, A+1, A}, and datatype SHALL be ignored.
REQ-019 Half loads SHALL return {A+1, A} zero-extended when datatype=1 and sign-extended from bit 15 when datatype=0.
REQ-020 Byte loads SHALL return byte A zero-extended when datatype=1 and sign-extended from bit 7 when datatype=0.
REQ-021 For a simultaneous read and write to the same byte, dataout SHALL show the old data before the edge and the new data immediately after the edge.
REQ-022 With WriteEn=0, memory SHALL be unchanged regardless of datain.

Reset
REQ-023 When reset=0, all 1024 bytes SHALL clear to 0x00 asynchronously, without waiting for clk.
REQ-024 While reset=0, stores SHALL be blocked, and dataout SHALL equal 0x00000000 for any access.
REQ-025 Deassertion of reset SHALL take effect at the next rising clk, with no extra cycle.
REQ-026 A reset asserted mid-sequence SHALL discard all prior contents.

Configuration
REQ-027 The block SHALL use the macro DATAMEM_BOUNDS_CHECK_EN.
REQ-028 With DATAMEM_BOUNDS_CHECK_EN defined, any access where address[31:10]!=0, or where any touched byte index exceeds 1023, SHALL have its store suppressed entirely and its load return 0x00000000.
REQ-029 Without DATAMEM_BOUNDS_CHECK_EN, address[31:10] SHALL be ignored and access SHALL alias with modulo-1024 wrap per REQ-014.

Verification
REQ-030 Word store 0x12345678 @0x04, then word load @0x04 -> 0x12345678.
REQ-031 After reset, WriteEn=0 with datain=0xDEADBEEF @0x08, then word load @0x08 -> 0x00000000.
REQ-032 Half store 0x1212EFEF @0x40 and 0xEFEF1212 @0x42 -> half signed @0x40 = 0xFFFFEFEF, unsigned @0x40 = 0x0000EFEF, signed @0x42 = 0x00001212, unsigned @0x42 = 0x00001212.
REQ-033 Byte stores 0xFFFF0040..0xFFFF0044 @0x50..0x54, then unsigned byte loads -> 0x40..0x44; unsigned byte load @0x05 after REQ-030 -> 0x00000056; signed byte load of 0x80 -> 0xFFFFFF80.
REQ-034 Word store @0x3FE without the macro -> bytes 0x3FE, 0x3FF, 0x000, 0x001 written; with the macro -> no write, and the load returns 0.
REQ-035 Reset pulsed low between clk edges after stores -> dataout reads 0 immediately, and a store on the same edge as reset=0 is ignored.
